// File: rtl/vin_pack.sv
// Packs nine 27-bit pixels into one 256-bit DDR3 write. Command and data
// strobes are retired independently before the next word is filled.
module vin_pack #(
  parameter int ADDR_WIDTH  = 29,
  parameter int FRAME_WORDS = 230400
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  vin_val_i,
  input  logic [26:0]           vin_data_i,
  output logic                  vin_rdy_o,
  output logic [ADDR_WIDTH-1:0] app_addr_o,
  output logic [2:0]            app_cmd_o,
  output logic                  app_en_o,
  input  logic                  app_rdy_i,
  output logic [255:0]          app_wdf_data_o,
  output logic                  app_wdf_wren_o,
  output logic                  app_wdf_end_o,
  input  logic                  app_wdf_rdy_i,
  output logic                  frame_done_o
);

  localparam int SLOTS = 9;
  localparam int WCW   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  typedef enum logic {FILL, ISSUE} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              fill_cnt_reg, fill_cnt_next;
  logic [WCW-1:0]          word_cnt_reg, word_cnt_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic                    en_reg, en_next;
  logic                    wren_reg, wren_next;
  logic                    frame_done_reg, frame_done_next;
  logic                    live_reg;
  logic [26:0]             slot_reg [SLOTS];

  logic accept;
  logic sof;
  logic cmd_done;
  logic data_done;
  logic last_word;

  assign accept    = vin_val_i && vin_rdy_o;
  assign sof       = vin_data_i[26];
  assign cmd_done  = !en_reg || app_rdy_i;
  assign data_done = !wren_reg || app_wdf_rdy_i;
  assign last_word = (word_cnt_reg == WCW'(FRAME_WORDS - 1));

  // live_reg keeps vin_rdy_o low during reset and rises on the first edge after it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) live_reg <= 1'b0;
    else       live_reg <= 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= FILL;
      fill_cnt_reg   <= '0;
      word_cnt_reg   <= '0;
      addr_reg       <= '0;
      en_reg         <= 1'b0;
      wren_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fill_cnt_reg   <= fill_cnt_next;
      word_cnt_reg   <= word_cnt_next;
      addr_reg       <= addr_next;
      en_reg         <= en_next;
      wren_reg       <= wren_next;
      frame_done_reg <= frame_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    fill_cnt_next   = fill_cnt_reg;
    word_cnt_next   = word_cnt_reg;
    addr_next       = addr_reg;
    en_next         = en_reg;
    wren_next       = wren_reg;
    frame_done_next = 1'b0;
    case (state_reg)
      FILL: begin
        if (accept) begin
          if (sof) begin
            // A start-of-frame pixel restarts both the word and the frame.
            fill_cnt_next = 4'd1;
            addr_next     = '0;
            word_cnt_next = '0;
          end else begin
            fill_cnt_next = fill_cnt_reg + 4'd1;
            if (fill_cnt_reg == 4'(SLOTS - 1)) begin
              state_next = ISSUE;
              en_next    = 1'b1;
              wren_next  = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (app_rdy_i)     en_next   = 1'b0;
        if (app_wdf_rdy_i) wren_next = 1'b0;
        if (cmd_done && data_done) begin
          state_next    = FILL;
          fill_cnt_next = '0;
          en_next       = 1'b0;
          wren_next     = 1'b0;
          if (last_word) begin
            addr_next       = '0;
            word_cnt_next   = '0;
            frame_done_next = 1'b1;
          end else begin
            addr_next     = addr_reg + ADDR_WIDTH'(8);
            word_cnt_next = word_cnt_reg + WCW'(1);
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Slots are only written in FILL, so the packed word is frozen during ISSUE.
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      logic slot_we;
      assign slot_we = accept && (sof ? (gi == 0) : (fill_cnt_reg == 4'(gi)));

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        slot_reg[gi] <= '0;
        else if (slot_we) slot_reg[gi] <= vin_data_i;
      end

      assign app_wdf_data_o[27*gi +: 27] = slot_reg[gi];
    end
  endgenerate

  assign app_wdf_data_o[255:243] = '0;
  assign vin_rdy_o      = live_reg && (state_reg == FILL);
  assign app_addr_o     = addr_reg;
  assign app_cmd_o      = 3'b000;
  assign app_en_o       = en_reg;
  assign app_wdf_wren_o = wren_reg;
  assign app_wdf_end_o  = wren_reg;
  assign frame_done_o   = frame_done_reg;

endmodule

// File: tb/tb_vin_pack.sv
// Scoreboard bench for vin_pack: a pixel-list model predicts each 256-bit write,
// a negedge monitor checks strobes, handshake payloads and frame_done.
module tb_vin_pack;

  localparam int AW = 29;
  localparam int FW = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          vin_val_i;
  logic [26:0]   vin_data_i;
  logic          vin_rdy_o;
  logic [AW-1:0] app_addr_o;
  logic [2:0]    app_cmd_o;
  logic          app_en_o;
  logic          app_rdy_i;
  logic [255:0]  app_wdf_data_o;
  logic          app_wdf_wren_o;
  logic          app_wdf_end_o;
  logic          app_wdf_rdy_i;
  logic          frame_done_o;

  vin_pack #(.ADDR_WIDTH(AW), .FRAME_WORDS(FW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .vin_val_i      (vin_val_i),
    .vin_data_i     (vin_data_i),
    .vin_rdy_o      (vin_rdy_o),
    .app_addr_o     (app_addr_o),
    .app_cmd_o      (app_cmd_o),
    .app_en_o       (app_en_o),
    .app_rdy_i      (app_rdy_i),
    .app_wdf_data_o (app_wdf_data_o),
    .app_wdf_wren_o (app_wdf_wren_o),
    .app_wdf_end_o  (app_wdf_end_o),
    .app_wdf_rdy_i  (app_wdf_rdy_i),
    .frame_done_o   (frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [255:0]  data;
    logic          last;
  } exp_t;

  exp_t        exp_q[$];
  logic [26:0] pix_q[$];
  int          word_idx = 0;
  logic        got_addr = 1'b0;
  logic        got_data = 1'b0;
  logic        fd_exp = 1'b0;
  logic        live_m;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_words = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect pixels, emit one word per nine, SOF restarts the frame.
  task automatic model_accept(input logic [26:0] p);
    exp_t e;
    if (p[26]) begin
      pix_q.delete();
      word_idx = 0;
    end
    pix_q.push_back(p);
    if (pix_q.size() == 9) begin
      e.data = '0;
      for (int k = 0; k < 9; k++) e.data[27*k +: 27] = pix_q[k];
      e.addr = AW'(word_idx * 8);
      e.last = (word_idx == FW - 1);
      word_idx = e.last ? 0 : word_idx + 1;
      exp_q.push_back(e);
      pix_q.delete();
    end
  endtask

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) live_m <= 1'b0;
    else       live_m <= 1'b1;
  end

  always @(negedge clk_i) begin
    if (rst_i) begin
      chk1("rst_en", app_en_o, 1'b0);
      chk1("rst_wren", app_wdf_wren_o, 1'b0);
      chk1("rst_end", app_wdf_end_o, 1'b0);
      chk1("rst_frame_done", frame_done_o, 1'b0);
      chk1("rst_vin_rdy", vin_rdy_o, 1'b0);
      chkv("rst_addr", 256'(app_addr_o), '0);
      chkv("rst_data", app_wdf_data_o, '0);
      exp_q.delete();
      pix_q.delete();
      word_idx = 0;
      got_addr = 1'b0;
      got_data = 1'b0;
      fd_exp   = 1'b0;
    end else begin
      chk1("frame_done", frame_done_o, fd_exp);
      fd_exp = 1'b0;
      chk1("vin_rdy", vin_rdy_o, live_m && (exp_q.size() == 0));
      chk1("app_en", app_en_o, (exp_q.size() != 0) && !got_addr);
      chk1("app_wdf_wren", app_wdf_wren_o, (exp_q.size() != 0) && !got_data);
      chk1("app_wdf_end", app_wdf_end_o, (exp_q.size() != 0) && !got_data);
      if (exp_q.size() != 0) begin
        if (app_en_o && app_rdy_i) begin
          chkv("app_addr", 256'(app_addr_o), 256'(exp_q[0].addr));
          chkv("app_cmd", 256'(app_cmd_o), '0);
          got_addr = 1'b1;
        end
        if (app_wdf_wren_o && app_wdf_rdy_i) begin
          chkv("app_wdf_data", app_wdf_data_o, exp_q[0].data);
          got_data = 1'b1;
        end
        if (got_addr && got_data) begin
          $display("word %0d addr=%0h data=%h last=%0b", n_words, exp_q[0].addr,
                   exp_q[0].data, exp_q[0].last);
          n_words++;
          fd_exp = exp_q[0].last;
          void'(exp_q.pop_front());
          got_addr = 1'b0;
          got_data = 1'b0;
        end
      end
      if (vin_val_i && vin_rdy_o) model_accept(vin_data_i);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send(input logic [26:0] p);
    bit took = 0;
    vin_val_i  = 1'b1;
    vin_data_i = p;
    for (int t = 0; t < 200 && !took; t++) begin
      @(negedge clk_i);
      took = vin_rdy_o;
      @(posedge clk_i);
      #1;
    end
    vin_val_i = 1'b0;
    if (!took) chk1("send_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int en_cycles;
    rst_i         = 1'b1;
    vin_val_i     = 1'b0;
    vin_data_i    = '0;
    app_rdy_i     = 1'b1;
    app_wdf_rdy_i = 1'b1;
    idle(3);
    rst_i = 1'b0;

    // Values 1..9 with SOF on the first pixel, always-ready memory.
    send(27'h4000001);
    for (int k = 2; k <= 9; k++) send(27'(k));
    idle(4);

    // Command side stalled five cycles, data side ready.
    app_rdy_i = 1'b0;
    for (int k = 0; k < 9; k++) send(27'(k + 27'h100));
    en_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (app_en_o) en_cycles++;
      @(posedge clk_i);
      #1;
      if (i == 4) app_rdy_i = 1'b1;
    end
    chkv("en_cycles", 256'(en_cycles), 256'(6));

    // One full frame plus one word: wrap back to address 0.
    send(27'h4000AA0);
    for (int k = 1; k < 36; k++) send(27'(k + 27'h200));
    idle(3);

    // Partial word abandoned by a fresh SOF.
    send(27'h4000011);
    for (int k = 1; k < 4; k++) send(27'(k + 27'h300));
    send(27'h4000FFF);
    for (int k = 1; k < 9; k++) send(27'(k + 27'h400));
    idle(3);

    // Reset while the command is pending.
    app_rdy_i = 1'b0;
    for (int k = 0; k < 9; k++) send(27'(k + 27'h500));
    chk1("pre_rst_en", app_en_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk1("async_rst_en", app_en_o, 1'b0);
    chk1("async_rst_wren", app_wdf_wren_o, 1'b0);
    chk1("async_rst_rdy", vin_rdy_o, 1'b0);
    chkv("async_rst_addr", 256'(app_addr_o), '0);
    chkv("async_rst_data", app_wdf_data_o, '0);
    idle(2);
    rst_i     = 1'b0;
    app_rdy_i = 1'b1;
    idle(3);
    for (int k = 0; k < 9; k++) send(27'(k + 27'h600));
    idle(3);

    // Randomised traffic with occasional SOF and back-pressure on both sides.
    for (int c = 0; c < 3000; c++) begin
      vin_val_i     = ($urandom_range(0, 3) != 0);
      vin_data_i    = {($urandom_range(0, 39) == 0), 26'($urandom)};
      app_rdy_i     = ($urandom_range(0, 3) != 0);
      app_wdf_rdy_i = ($urandom_range(0, 3) != 0);
      idle(1);
    end
    vin_val_i     = 1'b0;
    app_rdy_i     = 1'b1;
    app_wdf_rdy_i = 1'b1;
    idle(20);
    chk1("drain_empty", exp_q.size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
